traffic_light_controller: RTL and testbench

TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

---
 rtl/tl_pkg.sv | 56 +++++
 rtl/traffic_light_controller.sv | 133 +++++++++++++
 tb/tb_traffic_light_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared encodings for the traffic light controller: states, lamp codes, timer selection.
// The S_PED state exists only when TL_PED_WALK_EN is defined.
package tl_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_NS_G = 3'd1,
        S_NS_Y = 3'd2,
        S_EW_G = 3'd3,
        S_EW_Y = 3'd4
`ifdef TL_PED_WALK_EN
        ,
        S_PED  = 3'd5
`endif
    } state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic {
        TMR_SHORT = 1'b0,
        TMR_LONG  = 1'b1
    } tmr_sel_e;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
    } lamps_t;

    // Which delay each state waits on.
    function automatic tmr_sel_e timer_sel(input state_e s);
        case (s)
            S_NS_G, S_EW_G: return TMR_LONG;
`ifdef TL_PED_WALK_EN
            S_PED:          return TMR_LONG;
`endif
            default:        return TMR_SHORT;
        endcase
    endfunction

    function automatic lamps_t lamps_for(input state_e s);
        lamps_t l;
        l.ns = RED;
        l.ew = RED;
        case (s)
            S_NS_G:  l.ns = GRN;
            S_NS_Y:  l.ns = YEL;
            S_EW_G:  l.ew = GRN;
            S_EW_Y:  l.ew = YEL;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Two-road traffic light FSM driving an external long/short delay timer.
// Define TL_PED_WALK_EN to build the pedestrian all-red walk phase.
module traffic_light_controller
    import tl_pkg::*;
#(
    parameter bit SENSOR_GATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Timer_done,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic       Start_LongTimer,
    output logic       Start_ShortTimer,
    output logic [2:0] NS_light,
    output logic [2:0] EW_light,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    state_e state_q, state_d, next_state;
    logic   arm_q, arm_d;           // reset leaves an S_INIT entry pending
    logic   entry_q, entry_d;       // high in the start-pulse cycle of a state
    logic   done_acc_q, done_acc_d; // completion accepted, transition next cycle
    logic   car_pending_q, car_pending_d;
    logic   start_long_q, start_long_d;
    logic   start_short_q, start_short_d;
    lamps_t lamps_q, lamps_d;
    logic   enter;

`ifdef TL_PED_WALK_EN
    logic ped_pending_q, ped_pending_d;
    logic walk_q, walk_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state    = state_q;
        enter         = 1'b0;
        state_d       = state_q;
        entry_d       = 1'b0;
        arm_d         = 1'b0;
        done_acc_d    = done_acc_q | (Timer_done & ~entry_q & ~arm_q);
        start_long_d  = 1'b0;
        start_short_d = 1'b0;

        if (arm_q) begin
            enter      = 1'b1;
            next_state = S_INIT;
        end else if (done_acc_q) begin
            enter = 1'b1;
            case (state_q)
                S_INIT: next_state = S_NS_G;
                S_NS_G: next_state = (car_pending_q || !SENSOR_GATE) ? S_NS_Y : S_NS_G;
                S_NS_Y: next_state = S_EW_G;
                S_EW_G: next_state = S_EW_Y;
`ifdef TL_PED_WALK_EN
                S_EW_Y: next_state = ped_pending_q ? S_PED : S_NS_G;
                S_PED:  next_state = S_NS_G;
`else
                S_EW_Y: next_state = S_NS_G;
`endif
                default: next_state = S_INIT;
            endcase
        end

        if (enter) begin
            state_d       = next_state;
            entry_d       = 1'b1;
            done_acc_d    = 1'b0;
            start_long_d  = (timer_sel(next_state) == TMR_LONG);
            start_short_d = (timer_sel(next_state) == TMR_SHORT);
        end

        // A new car in the clearing cycle must still be remembered.
        car_pending_d = side_sensor | (car_pending_q & ~(enter & (next_state == S_EW_G)));
        lamps_d       = lamps_for(state_d);
    end

`ifdef TL_PED_WALK_EN
    always_comb begin
        ped_pending_d = ped_req | (ped_pending_q & ~(enter & (next_state == S_PED)));
        walk_d        = (state_d == S_PED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    assign ped_walk = walk_q;
`else
    assign ped_walk = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            arm_q         <= 1'b1;
            entry_q       <= 1'b0;
            done_acc_q    <= 1'b0;
            car_pending_q <= 1'b0;
            start_long_q  <= 1'b0;
            start_short_q <= 1'b0;
            lamps_q       <= lamps_for(S_INIT);
        end else begin
            state_q       <= state_d;
            arm_q         <= arm_d;
            entry_q       <= entry_d;
            done_acc_q    <= done_acc_d;
            car_pending_q <= car_pending_d;
            start_long_q  <= start_long_d;
            start_short_q <= start_short_d;
            lamps_q       <= lamps_d;
        end
    end

    assign Start_LongTimer  = start_long_q;
    assign Start_ShortTimer = start_short_q;
    assign NS_light         = lamps_q.ns;
    assign EW_light         = lamps_q.ew;
    assign state_o          = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller with a behavioural delay timer (long=100, short=16).
// Expectations for the pedestrian phase follow TL_PED_WALK_EN.
module tb_traffic_light_controller;

    localparam logic [2:0] ST_INIT = 3'd0;
    localparam logic [2:0] ST_NSG  = 3'd1;
    localparam logic [2:0] ST_NSY  = 3'd2;
    localparam logic [2:0] ST_EWG  = 3'd3;
    localparam logic [2:0] ST_EWY  = 3'd4;
    localparam logic [2:0] ST_PED  = 3'd5;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

`ifdef TL_PED_WALK_EN
    localparam logic [2:0] ST_X = ST_PED;
    localparam logic [2:0] NS_X = R;
    localparam logic       W_X  = 1'b1;
`else
    localparam logic [2:0] ST_X = ST_NSG;
    localparam logic [2:0] NS_X = G;
    localparam logic       W_X  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, side_sensor, ped_req, frc_done, mon_en;
    logic       Timer_done, Start_LongTimer, Start_ShortTimer, ped_walk;
    logic [2:0] NS_light, EW_light, state_o;
    int         n_tests = 0;
    int         n_fail  = 0;
    int unsigned tmr_cnt;

    traffic_light_controller #(.SENSOR_GATE(1'b1)) dut (
        .clk             (clk),
        .rst             (rst),
        .Timer_done      (Timer_done),
        .side_sensor     (side_sensor),
        .ped_req         (ped_req),
        .Start_LongTimer (Start_LongTimer),
        .Start_ShortTimer(Start_ShortTimer),
        .NS_light        (NS_light),
        .EW_light        (EW_light),
        .ped_walk        (ped_walk),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    // Delay timer beside the controller: done pulses N cycles after the trigger cycle.
    always @(posedge clk) begin
        if (rst)                   tmr_cnt <= 0;
        else if (Start_LongTimer)  tmr_cnt <= 100;
        else if (Start_ShortTimer) tmr_cnt <= 16;
        else if (tmr_cnt != 0)     tmr_cnt <= tmr_cnt - 1;
    end
    assign Timer_done = (tmr_cnt == 1) | frc_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("excl_green_yellow", 32'((NS_light[1:0] != 2'b00) && (EW_light[1:0] != 2'b00)), 32'd0);
            check("excl_starts", 32'(Start_LongTimer && Start_ShortTimer), 32'd0);
        end
    end

    typedef struct {
        int         dly;
        logic       rst, side, ped, frc;
        logic [2:0] st, ns, ew;
        logic       walk, lng, shrt;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] st, ns, ew;
        logic       walk, lng, shrt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t v(input int dly, input logic r, input logic s, input logic p,
                               input logic f, input logic [2:0] st, input logic [2:0] ns,
                               input logic [2:0] ew, input logic w, input logic l, input logic sh);
        vec_t x;
        x.dly = dly; x.rst = r; x.side = s; x.ped = p; x.frc = f;
        x.st = st; x.ns = ns; x.ew = ew; x.walk = w; x.lng = l; x.shrt = sh;
        return x;
    endfunction

    initial begin
        exp_t e;
        exp_t x;
        rst = 1'b1; side_sensor = 1'b0; ped_req = 1'b0; frc_done = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.state", 32'(state_o), 32'(ST_INIT));
        check("reset.ns", 32'(NS_light), 32'(R));
        check("reset.ew", 32'(EW_light), 32'(R));
        check("reset.walk", 32'(ped_walk), 32'd0);
        check("reset.long", 32'(Start_LongTimer), 32'd0);
        check("reset.short", 32'(Start_ShortTimer), 32'd0);
        mon_en = 1'b1;

        //            dly rst sd pd fr  state    ns  ew walk lng sht
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_INIT, R, R, 0, 0, 1));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_INIT, R, R, 0, 0, 0));
        vecs.push_back(v( 16, 0, 0, 0, 0, ST_INIT, R, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 1, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(100, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 1, 0));
        vecs.push_back(v(  9, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 1, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v( 91, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSY,  Y, R, 0, 0, 1));
        vecs.push_back(v( 18, 0, 0, 0, 0, ST_EWG,  R, G, 0, 1, 0));
        vecs.push_back(v(102, 0, 0, 0, 0, ST_EWY,  R, Y, 0, 0, 1));
        vecs.push_back(v( 17, 0, 0, 0, 0, ST_EWY,  R, Y, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 1, 0));
        vecs.push_back(v(  1, 0, 0, 0, 1, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  7, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 1, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v( 92, 0, 0, 0, 0, ST_NSY,  Y, R, 0, 0, 1));
        vecs.push_back(v( 18, 0, 0, 0, 0, ST_EWG,  R, G, 0, 1, 0));
        vecs.push_back(v( 49, 0, 0, 0, 0, ST_EWG,  R, G, 0, 0, 0));
        vecs.push_back(v(  1, 1, 0, 0, 0, ST_INIT, R, R, 0, 0, 0));
        vecs.push_back(v(  1, 1, 0, 0, 0, ST_INIT, R, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_INIT, R, R, 0, 0, 1));
        vecs.push_back(v( 18, 0, 0, 0, 0, ST_NSG,  G, R, 0, 1, 0));
        vecs.push_back(v(  6, 0, 0, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v(  1, 0, 1, 0, 0, ST_NSG,  G, R, 0, 0, 0));
        vecs.push_back(v( 95, 0, 0, 0, 0, ST_NSY,  Y, R, 0, 0, 1));
        vecs.push_back(v( 18, 0, 0, 0, 0, ST_EWG,  R, G, 0, 1, 0));
        vecs.push_back(v(  6, 0, 0, 0, 0, ST_EWG,  R, G, 0, 0, 0));
        vecs.push_back(v(  1, 0, 0, 1, 0, ST_EWG,  R, G, 0, 0, 0));
        vecs.push_back(v( 95, 0, 0, 0, 0, ST_EWY,  R, Y, 0, 0, 1));
        vecs.push_back(v( 18, 0, 0, 0, 0, ST_X,  NS_X, R, W_X, 1, 0));
        vecs.push_back(v(101, 0, 0, 0, 0, ST_X,  NS_X, R, W_X, 0, 0));
        vecs.push_back(v(  1, 0, 0, 0, 0, ST_NSG,  G, R, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst         = vecs[i].rst;
            side_sensor = vecs[i].side;
            ped_req     = vecs[i].ped;
            frc_done    = vecs[i].frc;
            x.idx = i; x.st = vecs[i].st; x.ns = vecs[i].ns; x.ew = vecs[i].ew;
            x.walk = vecs[i].walk; x.lng = vecs[i].lng; x.shrt = vecs[i].shrt;
            sb.push_back(x);
            repeat (vecs[i].dly) @(negedge clk);
            if (sb.size() == 0) begin
                check($sformatf("v%0d.scoreboard_empty", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d.state", e.idx), 32'(state_o), 32'(e.st));
                check($sformatf("v%0d.ns", e.idx), 32'(NS_light), 32'(e.ns));
                check($sformatf("v%0d.ew", e.idx), 32'(EW_light), 32'(e.ew));
                check($sformatf("v%0d.walk", e.idx), 32'(ped_walk), 32'(e.walk));
                check($sformatf("v%0d.long", e.idx), 32'(Start_LongTimer), 32'(e.lng));
                check($sformatf("v%0d.short", e.idx), 32'(Start_ShortTimer), 32'(e.shrt));
            end
        end

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
